neuron_feeder: RTL

NEURON_FEEDER -- requirements
Module: neuron_feeder

---
 rtl/neuron_feeder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/neuron_feeder.sv
// Streams pixels and weights from memory into a neuron calculator, then requests and latches its decision.
// Optional abort input is enabled by defining NEURON_FEEDER_ABORT_EN.
module neuron_feeder #(
   parameter int DATA_WIDTH       = 24,
   parameter int Addr_Depth       = 12,
   parameter int Weight_Percision = 5,
   parameter int NUM_PIXELS       = 4096
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          start,
`ifdef NEURON_FEEDER_ABORT_EN
   input  logic                          abort,
`endif
   output logic [Addr_Depth-1:0]         mem_addr,
   output logic                          mem_rd,
   input  logic [DATA_WIDTH-1:0]         img_data,
   input  logic [3*Weight_Percision-1:0] wgt_data,
   output logic [DATA_WIDTH-1:0]         x,
   output logic [3*Weight_Percision-1:0] w,
   output logic                          enable,
   output logic                          get_result,
   input  logic                          neuron_result,
   output logic                          busy,
   output logic                          done,
   output logic                          is_cat
);

   typedef enum logic [2:0] {IDLE, STREAM, DRAIN, RESULT, CAPTURE} state_t;

   // One extra counter bit lets NUM_PIXELS == 2**Addr_Depth reach its last address cleanly.
   localparam int            CW        = Addr_Depth + 1;
   localparam logic [CW-1:0] LastAddr  = CW'(NUM_PIXELS - 1);
   localparam logic [CW-1:0] DrainLast = CW'(2);
   localparam logic [CW-1:0] CountOne  = CW'(1);

   state_t                        r_state;
   state_t                        w_next;
   logic [CW-1:0]                 r_count;
   logic [CW-1:0]                 w_countNext;
   logic                          r_enable;
   logic [DATA_WIDTH-1:0]         r_x;
   logic [3*Weight_Percision-1:0] r_w;
   logic                          r_isCat;
   logic                          w_abort;

`ifdef NEURON_FEEDER_ABORT_EN
   assign w_abort = abort && (r_state != IDLE);
`else
   assign w_abort = 1'b0;
`endif

   always_comb begin
      w_next      = r_state;
      w_countNext = r_count;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_next      = STREAM;
               w_countNext = '0;
            end
         end
         STREAM: begin
            if (r_count == LastAddr) begin
               w_next      = DRAIN;
               w_countNext = '0;
            end else begin
               w_countNext = r_count + CountOne;
            end
         end
         DRAIN: begin
            if (r_count == DrainLast) begin
               w_next      = RESULT;
               w_countNext = '0;
            end else begin
               w_countNext = r_count + CountOne;
            end
         end
         RESULT:  w_next = CAPTURE;
         CAPTURE: w_next = IDLE;
         default: w_next = IDLE;
      endcase
      if (w_abort) begin
         w_next      = IDLE;
         w_countNext = '0;
      end
   end

   // enable trails mem_rd by one cycle, matching the memory read latency.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_count  <= '0;
         r_enable <= 1'b0;
         r_x      <= '0;
         r_w      <= '0;
         r_isCat  <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_count  <= w_countNext;
         r_enable <= mem_rd && !w_abort;
         if (r_enable) begin
            r_x <= img_data;
            r_w <= wgt_data;
         end
         if (r_state == CAPTURE && !w_abort) begin
            r_isCat <= neuron_result;
         end
      end
   end

   assign mem_rd     = (r_state == STREAM);
   assign mem_addr   = mem_rd ? r_count[Addr_Depth-1:0] : '0;
   assign get_result = (r_state == RESULT);
   assign done       = (r_state == CAPTURE) && !w_abort;
   assign busy       = (r_state != IDLE);
   assign enable     = r_enable;
   assign x          = r_x;
   assign w          = r_w;
   assign is_cat     = r_isCat;

endmodule
